// File: rtl/rps_input_conditioner.sv
// Button/PMOD front end: 2-flop sync, per-choice debounce, single-event FSM. PMOD merge with RPS_PMOD_EN.
// Latency: CHOICE_VALID DEBOUNCE_LEN+2 edges after the first edge sampling a press; all outputs registered.
// Backpressure: none; events are one-cycle pulses, re-trigger held off until release plus HOLDOFF cycles.
module rps_input_conditioner #(
  parameter int DEBOUNCE_LEN = 120000,
  parameter int HOLDOFF      = 1200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic       P1A1,
  input  logic       P1A2,
  input  logic       P1A3,
  output logic       CHOICE_VALID,
  output logic [1:0] CHOICE,
  output logic       ANY_HELD,
  output logic       CONFLICT
);

  localparam int CW = (DEBOUNCE_LEN > 2) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_LEN - 1);
  localparam logic [HW-1:0] CD_LOAD = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_COOL
  } state_t;

  logic [2:0] btn_s1, btn_s2;
  logic [2:0] raw;

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= {BTN3, BTN2, BTN1};
      btn_s2 <= btn_s1;
    end
  end

`ifdef RPS_PMOD_EN
  // PMOD switches are active-low, so their idle level is 1.
  logic [2:0] pmod_s1, pmod_s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pmod_s1 <= '1;
      pmod_s2 <= '1;
    end else begin
      pmod_s1 <= {P1A3, P1A2, P1A1};
      pmod_s2 <= pmod_s1;
    end
  end

  assign raw = btn_s2 | ~pmod_s2;
`else
  logic pmod_unused;
  assign pmod_unused = ^{P1A1, P1A2, P1A3};
  assign raw = btn_s2;
`endif

  logic [CW-1:0] db_cnt [3];
  logic [2:0]    stable;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic any_stable, multi_stable;
  assign any_stable   = |stable;
  assign multi_stable = (stable[0] & stable[1]) | (stable[0] & stable[2]) | (stable[1] & stable[2]);

  state_t        state_q, state_d;
  logic [HW-1:0] cool_q, cool_d;
  logic [1:0]    choice_d;
  logic          vld_d, conf_d;

  always_comb begin
    state_d  = state_q;
    cool_d   = cool_q;
    choice_d = CHOICE;
    vld_d    = 1'b0;
    conf_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_stable) begin
          if (stable[0])      choice_d = 2'd1;
          else if (stable[1]) choice_d = 2'd2;
          else                choice_d = 2'd3;
          vld_d   = 1'b1;
          conf_d  = multi_stable;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!any_stable) begin
          cool_d  = CD_LOAD;
          state_d = ST_COOL;
        end
      end
      ST_COOL: begin
        // A re-press during cooldown goes back to HELD silently.
        if (any_stable) begin
          state_d = ST_HELD;
        end else if (cool_q == '0) begin
          choice_d = 2'd0;
          state_d  = ST_IDLE;
        end else begin
          cool_d = cool_q - HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cool_q       <= '0;
      CHOICE       <= 2'd0;
      CHOICE_VALID <= 1'b0;
      CONFLICT     <= 1'b0;
      ANY_HELD     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cool_q       <= cool_d;
      CHOICE       <= choice_d;
      CHOICE_VALID <= vld_d;
      CONFLICT     <= conf_d;
      ANY_HELD     <= any_stable;
    end
  end

endmodule

// File: tb/tb_rps_input_conditioner.sv
// Directed bench for rps_input_conditioner with DEBOUNCE_LEN=4, HOLDOFF=3 (plus a HOLDOFF=12 instance
// for the cooldown-swallow case, where the cooldown must outlast the sync+debounce path of a re-press).
module tb_rps_input_conditioner;

  localparam int DL = 4;
  localparam int HO = 3;
  localparam int LAT = DL + 3;  // ticks from driving a press to seeing CHOICE_VALID

  logic       clk = 1'b0;
  logic       rst;
  logic       btn1, btn2, btn3;
  logic       p1a1, p1a2, p1a3;
  logic       vld, any_held, conflict;
  logic [1:0] choice;

  logic       swl_btn1;
  logic       swl_vld, swl_any, swl_conf;
  logic [1:0] swl_choice;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rps_input_conditioner #(.DEBOUNCE_LEN(DL), .HOLDOFF(HO)) dut (
    .CLK(clk), .RST(rst),
    .BTN1(btn1), .BTN2(btn2), .BTN3(btn3),
    .P1A1(p1a1), .P1A2(p1a2), .P1A3(p1a3),
    .CHOICE_VALID(vld), .CHOICE(choice), .ANY_HELD(any_held), .CONFLICT(conflict)
  );

  rps_input_conditioner #(.DEBOUNCE_LEN(DL), .HOLDOFF(12)) u_swl (
    .CLK(clk), .RST(rst),
    .BTN1(swl_btn1), .BTN2(1'b0), .BTN3(1'b0),
    .P1A1(1'b1), .P1A2(1'b1), .P1A3(1'b1),
    .CHOICE_VALID(swl_vld), .CHOICE(swl_choice), .ANY_HELD(swl_any), .CONFLICT(swl_conf)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input string tag, input int lat, input logic [1:0] ch, input logic cf);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (vld === 1'b1) seen = 1'b1;
    end
    if (!seen) n = -1;
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_choice"}, choice, ch);
    chk({tag, "_conflict"}, conflict, cf);
    tick();
    chk({tag, "_vld_one_cycle"}, vld, 1'b0);
    chk({tag, "_conflict_one_cycle"}, conflict, 1'b0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (vld !== 1'b0) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  initial begin
    int cnt;
    int hcnt;
    int n;
    rst = 1'b1;
    btn1 = 1'b1; btn2 = 1'b0; btn3 = 1'b0;
    p1a1 = 1'b1; p1a2 = 1'b1; p1a3 = 1'b1;
    swl_btn1 = 1'b0;

    // Reset held 3 cycles with BTN1 pressed: everything stays quiet.
    tick(3);
    chk("rst_vld", vld, 1'b0);
    chk("rst_choice", choice, 2'd0);
    chk("rst_any_held", any_held, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    rst = 1'b0;
    expect_pulse("rst_release", LAT, 2'd1, 1'b0);
    chk("rst_any_held_after", any_held, 1'b1);
    btn1 = 1'b0;
    tick(14);
    chk("rst_back_idle", choice, 2'd0);

    // Reset in the middle of a debounce throws away the partial count.
    btn2 = 1'b1;
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_pulse("rst_mid_debounce", LAT, 2'd2, 1'b0);
    btn2 = 1'b0;
    tick(14);
    chk("rst_mid_idle", choice, 2'd0);

    // Bounce: 1,0,1,0 for 2 cycles each, then a solid press.
    cnt = 0;
    for (int ph = 0; ph < 4; ph++) begin
      btn2 = (ph % 2 == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (vld !== 1'b0) cnt++;
      end
    end
    chk("bounce_quiet", cnt, 0);
    btn2 = 1'b1;
    expect_pulse("bounce", LAT, 2'd2, 1'b0);
    btn2 = 1'b0;
    tick(14);
    chk("bounce_idle", choice, 2'd0);

    // Two lines on the same cycle: ROCK wins with a conflict flag.
    btn3 = 1'b1;
`ifdef RPS_PMOD_EN
    p1a1 = 1'b0;
`else
    btn1 = 1'b1;
`endif
    expect_pulse("conflict", LAT, 2'd1, 1'b1);
    expect_quiet("conflict_held_quiet", 10);
    chk("conflict_held_choice", choice, 2'd1);
    btn3 = 1'b0; btn1 = 1'b0; p1a1 = 1'b1;
    tick(14);
    chk("conflict_idle", choice, 2'd0);

    // Full cycle: SCISSORS, release through cooldown, then PAPER.
    btn3 = 1'b1;
    expect_pulse("full_scissors", LAT, 2'd3, 1'b0);
    tick(3);
    btn3 = 1'b0;
    tick(DL + 2);
    chk("release_any_held_lag", any_held, 1'b1);
    tick();
    chk("release_any_held_clear", any_held, 1'b0);
    tick(HO - 1);
    chk("cool_choice_kept", choice, 2'd3);
    tick();
    chk("cool_choice_cleared", choice, 2'd0);
    btn2 = 1'b1;
    expect_pulse("full_paper", LAT, 2'd2, 1'b0);
    btn2 = 1'b0;
    tick(14);
    chk("full_idle", choice, 2'd0);

`ifdef RPS_PMOD_EN
    p1a2 = 1'b0;
    expect_pulse("pmod_paper", LAT, 2'd2, 1'b0);
    p1a2 = 1'b1;
    tick(14);
    chk("pmod_idle", choice, 2'd0);
`else
    p1a2 = 1'b0;
    cnt = 0;
    hcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vld !== 1'b0) cnt++;
      if (any_held !== 1'b0) hcnt++;
    end
    chk("pmod_off_no_event", cnt, 0);
    chk("pmod_off_no_held", hcnt, 0);
    p1a2 = 1'b1;
`endif

    // Cooldown swallow on the long-cooldown instance.
    swl_btn1 = 1'b1;
    n = 0;
    while (swl_vld !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (swl_vld !== 1'b1) n = -1;
    chk("swallow_first_lat", n, LAT);
    chk("swallow_first_choice", swl_choice, 2'd1);
    chk("swallow_first_conflict", swl_conf, 1'b0);
    tick();
    chk("swallow_first_one_cycle", swl_vld, 1'b0);
    tick(2);
    swl_btn1 = 1'b0;
    tick(DL + 3);
    chk("swallow_in_cool", swl_any, 1'b0);
    tick();
    swl_btn1 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (swl_vld !== 1'b0) cnt++;
    end
    chk("swallow_no_event", cnt, 0);
    chk("swallow_choice_kept", swl_choice, 2'd1);
    chk("swallow_any_held", swl_any, 1'b1);
    swl_btn1 = 1'b0;
    tick(22);
    chk("swallow_final_idle", swl_choice, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
